// File: rtl/ahb_dma_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the word-copy DMA initiator.
package ahb_dma_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_D = 3'd4,
        ST_ERR  = 3'd5
    } dma_state_t;

endpackage

// File: rtl/ahblite_dma_master.sv
// Single-channel AHB-Lite DMA initiator: copies LEN words from SRC to DST, one read and
// one write NONSEQ transfer per word, with sticky DONE/ERROR and a one-cycle IRQ per job.
module ahblite_dma_master
    import ahb_dma_pkg::*;
#(
    parameter int          LEN_W       = 16,
    parameter logic [3:0]  HPROT_VALUE = 4'b0011,
    parameter bit          SRC_INC     = 1'b1,
    parameter bit          DST_INC     = 1'b1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             START,
    input  logic             ABORT,
    input  logic [31:0]      SRC_ADDR,
    input  logic [31:0]      DST_ADDR,
    input  logic [LEN_W-1:0] LEN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic             IRQ,
    output logic [LEN_W-1:0] REMAIN,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    dma_state_t       state_reg;
    logic [31:0]      src_reg;
    logic [31:0]      dst_reg;
    logic             abort_reg;
    logic [31:0]      src_next;
    logic [31:0]      dst_next;
    logic [LEN_W-1:0] remain_next;

    assign src_next    = SRC_INC ? src_reg + 32'd4 : src_reg;
    assign dst_next    = DST_INC ? dst_reg + 32'd4 : dst_reg;
    assign remain_next = REMAIN - LEN_W'(1);

    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VALUE;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= ST_IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            abort_reg <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
            IRQ       <= 1'b0;
            REMAIN    <= '0;
            HADDR     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
        end else begin
            IRQ <= 1'b0;
            if (BUSY && ABORT)
                abort_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        DONE      <= 1'b0;
                        ERROR     <= 1'b0;
                        abort_reg <= 1'b0;
                        REMAIN    <= LEN;
                        if (LEN != '0) begin
                            src_reg   <= SRC_ADDR & 32'hFFFF_FFFC;
                            dst_reg   <= DST_ADDR & 32'hFFFF_FFFC;
                            BUSY      <= 1'b1;
                            HADDR     <= SRC_ADDR & 32'hFFFF_FFFC;
                            HTRANS    <= HTRANS_NONSEQ;
                            HWRITE    <= 1'b0;
                            state_reg <= ST_RD_A;
                        end else begin
                            DONE <= 1'b1;
                            IRQ  <= 1'b1;
                        end
                    end
                end
                ST_RD_A, ST_WR_A: begin
                    if (HREADY) begin
                        HTRANS    <= HTRANS_IDLE;
                        state_reg <= (state_reg == ST_RD_A) ? ST_RD_D : ST_WR_D;
                    end
                end
                ST_RD_D, ST_WR_D: begin
                    if (HRESP) begin
                        // A well-formed error response takes two cycles; a one-cycle
                        // error (HREADY already high) is closed out immediately.
                        if (HREADY) begin
                            ERROR     <= 1'b1;
                            BUSY      <= 1'b0;
                            IRQ       <= 1'b1;
                            abort_reg <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_ERR;
                        end
                    end else if (HREADY) begin
                        if (state_reg == ST_RD_D) begin
                            HWDATA    <= HRDATA;
                            HADDR     <= dst_reg;
                            HWRITE    <= 1'b1;
                            HTRANS    <= HTRANS_NONSEQ;
                            state_reg <= ST_WR_A;
                        end else begin
                            REMAIN  <= remain_next;
                            src_reg <= src_next;
                            dst_reg <= dst_next;
                            if (remain_next == '0 || abort_reg || ABORT) begin
                                BUSY      <= 1'b0;
                                IRQ       <= 1'b1;
                                DONE      <= (remain_next == '0);
                                HWRITE    <= 1'b0;
                                abort_reg <= 1'b0;
                                state_reg <= ST_IDLE;
                            end else begin
                                HADDR     <= src_next;
                                HWRITE    <= 1'b0;
                                HTRANS    <= HTRANS_NONSEQ;
                                state_reg <= ST_RD_A;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    if (HREADY) begin
                        ERROR     <= 1'b1;
                        BUSY      <= 1'b0;
                        IRQ       <= 1'b1;
                        abort_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    HTRANS    <= HTRANS_IDLE;
                    BUSY      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahblite_dma_master.sv
// Directed bench for ahblite_dma_master: a small AHB-Lite slave with wait states and
// error injection serves two DMA instances (incrementing and fixed destination).
module tb_ahblite_dma_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;

    logic        s_hready, s_hresp;
    logic [31:0] s_hrdata;

    logic        b0, d0, e0, i0, w0, l0, b1, d1, e1, i1, w1, l1;
    logic [15:0] r0, r1;
    logic [31:0] a0, a1, wd0, wd1;
    logic [1:0]  t0, t1;
    logic [2:0]  sz0, sz1, bu0, bu1;
    logic [3:0]  p0, p1;

    ahblite_dma_master u0 (
        .HCLK(clk), .HRESETn(rst_n), .START(start && !sel), .ABORT(abort && !sel),
        .SRC_ADDR(src_addr), .DST_ADDR(dst_addr), .LEN(len),
        .BUSY(b0), .DONE(d0), .ERROR(e0), .IRQ(i0), .REMAIN(r0),
        .HADDR(a0), .HTRANS(t0), .HWRITE(w0), .HSIZE(sz0), .HBURST(bu0), .HPROT(p0),
        .HMASTLOCK(l0), .HWDATA(wd0), .HRDATA(s_hrdata), .HREADY(s_hready), .HRESP(s_hresp)
    );

    ahblite_dma_master #(.DST_INC(1'b0)) u1 (
        .HCLK(clk), .HRESETn(rst_n), .START(start && sel), .ABORT(abort && sel),
        .SRC_ADDR(src_addr), .DST_ADDR(dst_addr), .LEN(len),
        .BUSY(b1), .DONE(d1), .ERROR(e1), .IRQ(i1), .REMAIN(r1),
        .HADDR(a1), .HTRANS(t1), .HWRITE(w1), .HSIZE(sz1), .HBURST(bu1), .HPROT(p1),
        .HMASTLOCK(l1), .HWDATA(wd1), .HRDATA(s_hrdata), .HREADY(s_hready), .HRESP(s_hresp)
    );

    logic        m_busy, m_done, m_error, m_irq, m_hwrite;
    logic [15:0] m_remain;
    logic [31:0] m_haddr, m_hwdata;
    logic [1:0]  m_htrans;
    assign m_busy   = sel ? b1  : b0;
    assign m_done   = sel ? d1  : d0;
    assign m_error  = sel ? e1  : e0;
    assign m_irq    = sel ? i1  : i0;
    assign m_hwrite = sel ? w1  : w0;
    assign m_remain = sel ? r1  : r0;
    assign m_haddr  = sel ? a1  : a0;
    assign m_hwdata = sel ? wd1 : wd0;
    assign m_htrans = sel ? t1  : t0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    // ---------------- slave model ----------------
    int          cfg_ws = 0;
    int          cfg_err_read = -1;
    logic        dp_active, dp_write, dp_err, err_stage;
    logic [31:0] dp_addr, dp_wfirst;
    int          wait_cnt, read_idx;
    int          hw_unstable = 0;
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    always_comb begin
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        s_hrdata = 32'h0;
        if (dp_active) begin
            if (dp_err) begin
                s_hresp  = 1'b1;
                s_hready = err_stage;
            end else begin
                s_hready = (wait_cnt == 0);
            end
            if (!dp_write) s_hrdata = pat(dp_addr);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_active <= 1'b0; dp_write <= 1'b0; dp_err <= 1'b0; err_stage <= 1'b0;
            dp_addr <= '0; dp_wfirst <= '0; wait_cnt <= 0; read_idx <= 0;
        end else begin
            if (dp_active) begin
                if (dp_write && m_hwdata != dp_wfirst) hw_unstable <= hw_unstable + 1;
                if (dp_err) begin
                    if (err_stage) begin dp_active <= 1'b0; err_stage <= 1'b0; end
                    else err_stage <= 1'b1;
                end else if (wait_cnt != 0) begin
                    wait_cnt <= wait_cnt - 1;
                end else begin
                    dp_active <= 1'b0;
                    if (dp_write) begin
                        wlog_addr.push_back(dp_addr);
                        wlog_data.push_back(m_hwdata);
                        $display("[TB] write addr=%h data=%h", dp_addr, m_hwdata);
                    end
                end
            end
            if (s_hready && m_htrans == 2'b10) begin
                dp_active <= 1'b1;
                dp_addr   <= m_haddr;
                dp_write  <= m_hwrite;
                dp_wfirst <= m_hwdata;
                wait_cnt  <= cfg_ws;
                err_stage <= 1'b0;
                dp_err    <= !m_hwrite && (read_idx + 1 == cfg_err_read);
                if (!m_hwrite) read_idx <= read_idx + 1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int busy_cyc = 0, irq_cnt = 0, nonseq_cyc = 0, err_cyc = 0, err_bad = 0;
    always @(negedge clk) begin
        if (m_busy) busy_cyc <= busy_cyc + 1;
        if (m_irq) irq_cnt <= irq_cnt + 1;
        if (m_htrans == 2'b10) nonseq_cyc <= nonseq_cyc + 1;
        if (s_hresp) begin
            err_cyc <= err_cyc + 1;
            if (m_htrans != 2'b00) err_bad <= err_bad + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int sb_busy, sb_irq, sb_nonseq, sb_err, sb_bad, sb_wr, sb_unst;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        sb_busy = busy_cyc; sb_irq = irq_cnt; sb_nonseq = nonseq_cyc;
        sb_err = err_cyc; sb_bad = err_bad; sb_wr = wlog_addr.size(); sb_unst = hw_unstable;
    endtask

    task automatic run_job(input logic s, input logic [31:0] sa, input logic [31:0] da,
                           input logic [15:0] n, input logic ab);
        snap();
        sel = s; src_addr = sa; dst_addr = da; len = n; start = 1'b1; abort = ab;
        tick();
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_irq(input int max_cyc);
        int n = 0;
        while (!m_irq && n < max_cyc) begin
            tick();
            n++;
        end
        check_val("irq_seen", {31'b0, m_irq}, 32'd1);
        tick();
    endtask

    task automatic check_writes(input string tag, input int cnt, input logic [31:0] sa,
                                input logic [31:0] da, input logic dinc);
        check_val({tag, "_wcount"}, wlog_addr.size() - sb_wr, cnt);
        for (int i = 0; i < cnt && sb_wr + i < wlog_addr.size(); i++) begin
            check_val({tag, "_waddr"}, wlog_addr[sb_wr + i], dinc ? da + 32'(4 * i) : da);
            check_val({tag, "_wdata"}, wlog_data[sb_wr + i], pat(sa + 32'(4 * i)));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        // reset state
        check_val("rst_htrans", {30'b0, t0}, 32'd0);
        check_val("rst_haddr", a0, 32'd0);
        check_val("rst_flags", {28'b0, b0, d0, e0, i0}, 32'd0);
        check_val("rst_remain", {16'b0, r0}, 32'd0);
        check_val("rst_hwdata", wd0, 32'd0);
        check_val("const_ctrl", {21'b0, sz0, bu0, p0, l0}, {21'b0, 3'b010, 3'b000, 4'b0011, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: LEN=4 zero-wait copy
        cfg_ws = 0;
        run_job(1'b0, 32'h2000_0000, 32'h2000_1000, 16'd4, 1'b0);
        check_val("t1_busy_start", {31'b0, m_busy}, 32'd1);
        wait_irq(100);
        check_writes("t1", 4, 32'h2000_0000, 32'h2000_1000, 1'b1);
        check_val("t1_busy_cycles", busy_cyc - sb_busy, 32'd16);
        check_val("t1_nonseq", nonseq_cyc - sb_nonseq, 32'd8);
        check_val("t1_irq_count", irq_cnt - sb_irq, 32'd1);
        check_val("t1_status", {29'b0, m_busy, m_done, m_error}, 32'b010);
        check_val("t1_remain", {16'b0, m_remain}, 32'd0);

        // 2: LEN=0
        run_job(1'b0, 32'h2000_0000, 32'h2000_1000, 16'd0, 1'b0);
        check_val("t2_irq_done", {29'b0, m_irq, m_done, m_busy}, 32'b110);
        tick();
        check_val("t2_irq_low", {31'b0, m_irq}, 32'd0);
        repeat (3) tick();
        check_val("t2_nonseq", nonseq_cyc - sb_nonseq, 32'd0);
        check_val("t2_busy_cycles", busy_cyc - sb_busy, 32'd0);

        // 3: fixed destination, 2 wait states per data phase
        cfg_ws = 2;
        run_job(1'b1, 32'h2000_0040, 32'h5000_0000, 16'd3, 1'b0);
        wait_irq(200);
        check_writes("t3", 3, 32'h2000_0040, 32'h5000_0000, 1'b0);
        check_val("t3_busy_cycles", busy_cyc - sb_busy, 32'd24);
        check_val("t3_hwdata_stable", hw_unstable - sb_unst, 32'd0);
        check_val("t3_done", {30'b0, m_done, m_error}, 32'b10);
        cfg_ws = 0;

        // 4: error on second read of LEN=5
        cfg_err_read = read_idx + 2;
        run_job(1'b0, 32'h2000_0080, 32'h2000_1080, 16'd5, 1'b0);
        wait_irq(100);
        cfg_err_read = -1;
        check_writes("t4", 1, 32'h2000_0080, 32'h2000_1080, 1'b1);
        check_val("t4_status", {29'b0, m_busy, m_done, m_error}, 32'b001);
        check_val("t4_remain", {16'b0, m_remain}, 32'd4);
        check_val("t4_irq_count", irq_cnt - sb_irq, 32'd1);
        check_val("t4_err_cycles", err_cyc - sb_err, 32'd2);
        check_val("t4_err_htrans", err_bad - sb_bad, 32'd0);

        // 5: ABORT during word 3 of LEN=8, START while busy ignored
        run_job(1'b0, 32'h2000_0100, 32'h2000_1100, 16'd8, 1'b0);
        repeat (9) tick();
        abort = 1'b1; start = 1'b1; len = 16'd3;
        tick();
        abort = 1'b0; start = 1'b0;
        wait_irq(100);
        check_writes("t5", 3, 32'h2000_0100, 32'h2000_1100, 1'b1);
        check_val("t5_remain", {16'b0, m_remain}, 32'd5);
        check_val("t5_status", {29'b0, m_busy, m_done, m_error}, 32'b000);
        check_val("t5_irq_count", irq_cnt - sb_irq, 32'd1);
        repeat (3) tick();
        check_val("t5_stays_idle", {31'b0, m_busy}, 32'd0);

        // 6: reset asserted in WR_D
        run_job(1'b0, 32'h2000_0000, 32'h2000_1000, 16'd4, 1'b0);
        repeat (7) tick();
        check_val("t6_in_write", {31'b0, m_hwrite}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_bus", {m_hwdata[29:0], m_htrans}, 32'd0);
        check_val("t6_rst_haddr", m_haddr, 32'd0);
        check_val("t6_rst_flags", {12'b0, m_remain, m_busy, m_done, m_error, m_irq}, 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        check_val("t6_no_irq", irq_cnt - sb_irq, 32'd0);
        run_job(1'b0, 32'h2000_0180, 32'h2000_1180, 16'd2, 1'b0);
        wait_irq(100);
        check_writes("t6", 2, 32'h2000_0180, 32'h2000_1180, 1'b1);
        check_val("t6_done", {30'b0, m_done, m_error}, 32'b10);

        // 7: START and ABORT together in IDLE -> ABORT dropped
        run_job(1'b0, 32'h2000_01C0, 32'h2000_11C0, 16'd2, 1'b1);
        wait_irq(100);
        check_writes("t7", 2, 32'h2000_01C0, 32'h2000_11C0, 1'b1);
        check_val("t7_remain", {16'b0, m_remain}, 32'd0);
        check_val("t7_done", {31'b0, m_done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
